// File: rtl/riscq_image_streamer.sv
// Host-side loader for the RISCQ init stream: pulses CPU reset low, then streams the
// instruction and data images, each closed by a terminator word, over valid/ready.
module riscq_image_streamer #(
  parameter int                ADDR_W         = 12,
  parameter int                DATA_W         = 32,
  parameter logic [DATA_W-1:0] TERM           = DATA_W'(32'hFFFF_FFFF),
  parameter int                CPU_RST_CYCLES = 10
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  input  logic              i_start,
  input  logic [ADDR_W:0]   i_inst_len,
  input  logic [ADDR_W:0]   i_data_len,
  output logic              o_imem_rd_en,
  output logic [ADDR_W-1:0] o_imem_raddr,
  input  logic [DATA_W-1:0] i_imem_rdata,
  output logic              o_dmem_rd_en,
  output logic [ADDR_W-1:0] o_dmem_raddr,
  input  logic [DATA_W-1:0] i_dmem_rdata,
  output logic              o_cpu_rst,
  output logic [DATA_W-1:0] o_data,
  output logic              o_data_valid,
  input  logic              i_ready,
  output logic              o_busy,
  output logic              o_done,
  output logic              o_collision
);

  localparam int RC_W = (CPU_RST_CYCLES > 1) ? $clog2(CPU_RST_CYCLES) : 1;

  typedef enum logic [2:0] {
    IDLE, CPU_RST, INST, INST_TERM, DATA, DATA_TERM, DONE
  } state_t;

  typedef enum logic [1:0] {
    SRC_INST, SRC_DATA, SRC_TERM
  } src_t;

  state_t            state;
  logic [RC_W-1:0]   rst_cnt;
  logic [ADDR_W:0]   inst_len_q;
  logic [ADDR_W:0]   data_len_q;
  logic [ADDR_W:0]   rd_addr;
  logic              term_sent;

  logic              inflight_v;
  src_t              inflight_src;
  logic              skid_v;
  logic [DATA_W-1:0] skid_data;

  logic              pop;
  logic [1:0]        occ;
  logic              room;
  logic              issue_term;
  logic              issue;
  src_t              issue_src;
  logic              start_acc;
  logic              last_xfer;
  logic [DATA_W-1:0] in_word;
  logic [ADDR_W:0]   rd_addr_nxt;

  // Terminators travel through the same one-cycle slot as buffer reads, so the
  // output queue sees a uniform latency and section boundaries need no bubbles.
  always_comb begin
    pop          = o_data_valid & i_ready;
    occ          = 2'(o_data_valid) + 2'(skid_v) + 2'(inflight_v) - 2'(pop);
    room         = (occ < 2'd2);
    start_acc    = (state == IDLE) && i_start;
    o_imem_rd_en = (state == INST) && room;
    o_dmem_rd_en = (state == DATA) && room;
    issue_term   = room && ((state == INST_TERM) || ((state == DATA_TERM) && !term_sent));
    issue        = o_imem_rd_en | o_dmem_rd_en | issue_term;
    o_imem_raddr = o_imem_rd_en ? rd_addr[ADDR_W-1:0] : '0;
    o_dmem_raddr = o_dmem_rd_en ? rd_addr[ADDR_W-1:0] : '0;
    rd_addr_nxt  = rd_addr + (ADDR_W+1)'(1);
    last_xfer    = pop && (state == DATA_TERM) && term_sent && !skid_v && !inflight_v;

    issue_src = SRC_TERM;
    if (o_imem_rd_en)      issue_src = SRC_INST;
    else if (o_dmem_rd_en) issue_src = SRC_DATA;

    case (inflight_src)
      SRC_INST: in_word = i_imem_rdata;
      SRC_DATA: in_word = i_dmem_rdata;
      default:  in_word = TERM;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state      <= IDLE;
      rst_cnt    <= '0;
      inst_len_q <= '0;
      data_len_q <= '0;
      rd_addr    <= '0;
      term_sent  <= 1'b0;
      o_cpu_rst  <= 1'b1;
      o_busy     <= 1'b0;
      o_done     <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (i_start) begin
            inst_len_q <= i_inst_len;
            data_len_q <= i_data_len;
            rst_cnt    <= '0;
            rd_addr    <= '0;
            term_sent  <= 1'b0;
            o_cpu_rst  <= 1'b0;
            o_busy     <= 1'b1;
            state      <= CPU_RST;
          end
        end
        CPU_RST: begin
          if (rst_cnt == RC_W'(CPU_RST_CYCLES - 1)) begin
            o_cpu_rst <= 1'b1;
            rd_addr   <= '0;
            state     <= (inst_len_q == '0) ? INST_TERM : INST;
          end else begin
            rst_cnt <= rst_cnt + RC_W'(1);
          end
        end
        INST: begin
          if (o_imem_rd_en) begin
            if (rd_addr_nxt == inst_len_q) begin
              rd_addr <= '0;
              state   <= INST_TERM;
            end else begin
              rd_addr <= rd_addr_nxt;
            end
          end
        end
        INST_TERM: begin
          if (issue_term) begin
            state <= (data_len_q == '0) ? DATA_TERM : DATA;
          end
        end
        DATA: begin
          if (o_dmem_rd_en) begin
            if (rd_addr_nxt == data_len_q) begin
              rd_addr <= '0;
              state   <= DATA_TERM;
            end else begin
              rd_addr <= rd_addr_nxt;
            end
          end
        end
        DATA_TERM: begin
          if (issue_term) term_sent <= 1'b1;
          if (last_xfer) begin
            o_done <= 1'b1;
            o_busy <= 1'b0;
            state  <= DONE;
          end
        end
        DONE: begin
          o_done <= 1'b0;
          state  <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Output register plus skid; the issue credit guarantees the skid is free
  // whenever a word arrives during a stall.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      inflight_v   <= 1'b0;
      inflight_src <= SRC_TERM;
      skid_v       <= 1'b0;
      skid_data    <= '0;
      o_data       <= '0;
      o_data_valid <= 1'b0;
      o_collision  <= 1'b0;
    end else begin
      inflight_v   <= issue;
      inflight_src <= issue_src;

      if (start_acc) begin
        o_collision <= 1'b0;
      end else if (inflight_v && (inflight_src != SRC_TERM) && (in_word == TERM)) begin
        o_collision <= 1'b1;
      end

      if (!o_data_valid || pop) begin
        if (skid_v) begin
          o_data       <= skid_data;
          o_data_valid <= 1'b1;
          skid_v       <= inflight_v;
          skid_data    <= inflight_v ? in_word : '0;
        end else if (inflight_v) begin
          o_data       <= in_word;
          o_data_valid <= 1'b1;
        end else begin
          o_data       <= '0;
          o_data_valid <= 1'b0;
        end
      end else if (inflight_v) begin
        skid_data <= in_word;
        skid_v    <= 1'b1;
      end
    end
  end

endmodule

// File: doc/riscq_image_streamer.md
# riscq_image_streamer

Host-side loader that produces the RISCQ initialization stream. On a start pulse it pulses the CPU reset low, then reads an instruction image and a data image from two synchronous-read buffers. It emits them as a 32-bit valid/ready word stream, closing each section with the terminator word. It sits between the host image buffers and the RISCQ init receiver, driving that receiver's `i_cpu_rst`, `i_data` and `i_data_valid`.

## Interface

- `ADDR_W`, 12: image buffer address width (max 4096 words per section).
- `DATA_W`, 32: stream word width.
- `TERM`, 32'hFFFF_FFFF: section terminator word.
- `CPU_RST_CYCLES`, 10: cycles `o_cpu_rst` is held low before streaming (≥1).
- `i_clk` in 1: clock.
- `i_rst_n` in 1: asynchronous, active-low reset.
- `i_start` in 1: one-cycle start request; sampled only in IDLE.
- `i_inst_len` in ADDR_W+1: instruction word count (0..2^ADDR_W), latched at start.
- `i_data_len` in ADDR_W+1: data word count, latched at start.
- `o_imem_rd_en` out 1: instruction buffer read enable.
- `o_imem_raddr` out ADDR_W: instruction buffer read address.
- `i_imem_rdata` in DATA_W: instruction buffer data, valid 1 cycle after `o_imem_rd_en`.
- `o_dmem_rd_en`, `o_dmem_raddr`, `i_dmem_rdata`: same for the data buffer.
- `o_cpu_rst` out 1: CPU/init reset to receiver, active-low.
- `o_data` out DATA_W: stream word; 0 whenever `o_data_valid`=0.
- `o_data_valid` out 1: stream word valid.
- `i_ready` in 1: sink ready; a word transfers when `o_data_valid & i_ready`.
- `o_busy` out 1: high from accepted start until `o_done`.
- `o_done` out 1: one-cycle pulse after the final terminator transfers.
- `o_collision` out 1: sticky; an image word equal to `TERM` was sent.

## Operation

- Reset values: `o_cpu_rst`=1. `o_data`=0. `o_data_valid`, `o_*_rd_en`, `o_*_raddr`, `o_busy`, `o_done` and `o_collision` are all 0. FSM is in IDLE.
- FSM states: IDLE → CPU_RST → INST → INST_TERM → DATA → DATA_TERM → DONE → IDLE.
- IDLE: when `i_start`=1, latch both lengths, clear `o_collision`, set `o_busy`, and go to CPU_RST.
- CPU_RST: `o_cpu_rst`=0 for exactly CPU_RST_CYCLES cycles, then go to INST.
- INST: read imem addresses 0..inst_len-1 in order and emit each word. A length of 0 goes directly to INST_TERM.
- INST_TERM: emit `TERM` once.
- DATA and DATA_TERM: same as INST and INST_TERM, using the dmem buffer.
- DONE: pulse `o_done`, clear `o_busy`, return to IDLE.
- Reads are prefetched through a 2-entry output queue (output register plus skid). A read is issued only when queued words plus in-flight reads < 2. No word is dropped or duplicated under any `i_ready` pattern.
- `o_data` and `o_data_valid` are held stable while `o_data_valid`=1 and `i_ready`=0.
- Collision: an image word equal to `TERM` is still sent, and `o_collision` is set. The flag holds until the next accepted start.
- `i_start` while busy is ignored. Lengths are sampled only on an accepted start.
- Address counters are ADDR_W+1 bits wide. A length of 2^ADDR_W reads the full buffer with no wrap.
- Asynchronous reset mid-operation: all outputs return to reset values immediately, including `o_cpu_rst`=1. The transfer is abandoned.

## Timing

- Start is accepted at cycle S.
- `o_cpu_rst`=0 during cycles S+1..S+CPU_RST_CYCLES, and 1 from S+CPU_RST_CYCLES+1.
- The first imem read (addr 0) is issued at S+CPU_RST_CYCLES+1.
- The first word is valid at S+CPU_RST_CYCLES+3 (read latency 1, plus the output register).
- With `i_ready` held at 1, all words are back-to-back with no bubbles. This includes the inst section → `TERM` → data section → `TERM` boundaries; dmem is prefetched during INST_TERM.
- Total valid cycles = inst_len + data_len + 2.
- `o_done` is asserted the cycle after the final `TERM` transfers. `o_busy` falls in the same cycle.
- A new start is accepted the cycle after `o_done`.

## Test plan

- Reset: hold `i_rst_n`=0 and toggle `i_start` → all outputs at reset values, `o_cpu_rst`=1, no reads issued.
- Full load:
  - Stimulus: inst_len=32, data_len=32, both buffers contain word[i]=i, `i_ready`=1, start at S, CPU_RST_CYCLES=10.
  - Required response: `o_cpu_rst` low S+1..S+10. Stream 0..31, FFFFFFFF, 0..31, FFFFFFFF on consecutive cycles S+13..S+78. `o_done` at S+79.
- Zero lengths: inst_len=0, data_len=0 → exactly two `TERM` words on consecutive cycles, no `rd_en` asserted, then `o_done`.
- Backpressure: inst_len=data_len=8, `i_ready` random (50%) → the transferred sequence is identical to the full-load order. `o_data` is stable on every stalled valid cycle. `o_done` follows the last transfer.
- Collision: imem word at addr 5 = FFFFFFFF → the word is sent in place and `o_collision` rises. It stays high through `o_done` and clears on the next start.
- Abort/restart:
  - Stimulus: `i_start` pulsed while busy; later `i_rst_n` asserted low while at inst word 10; then a fresh start.
  - Required response: the first `i_start` is ignored. Reset returns all outputs to reset values and `o_cpu_rst` to 1. The fresh start produces a complete, correct stream from address 0.
